// File: rtl/pipeline_retire_monitor.sv
// Retirement monitor for mips_pipeline: classifies retired instructions, keeps saturating counters,
// buffers retire records in a FWFT trace FIFO and halts on a cycle budget. Optional macro: MON_WD_EN.
module pipeline_retire_monitor #(
   parameter int CNT_W       = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int CYCLE_LIMIT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             retire_valid,
   input  logic [31:0]      retire_pc,
   input  logic [31:0]      retire_instr,
   input  logic [31:0]      retire_wd,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic [3:0]       trace_class,
   output logic [31:0]      trace_wd,
   input  logic [3:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_rdata,
   output logic             halt,
   output logic             fifo_full
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef MON_WD_EN
   localparam int EW = 68;
`else
   localparam int EW = 36;
`endif
   localparam logic [CNT_W-1:0] LIMIT_M1 = (CYCLE_LIMIT > 0) ? CNT_W'(CYCLE_LIMIT - 1) : '0;
   localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   function automatic logic [3:0] decode_class(input logic [31:0] instr);
      logic [3:0] cls;
      if (instr[31:26] == 6'd0) begin
         case (instr[5:0])
            6'd32:   cls = 4'd0;
            6'd34:   cls = 4'd1;
            6'd36:   cls = 4'd2;
            6'd37:   cls = 4'd3;
            default: cls = 4'd15;
         endcase
      end else begin
         case (instr[31:26])
            6'd35:   cls = 4'd4;
            6'd43:   cls = 4'd5;
            6'd4:    cls = 4'd6;
            6'd2:    cls = 4'd7;
            default: cls = 4'd15;
         endcase
      end
      return cls;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   state_t           state_r;
   logic             halt_r;
   logic [CNT_W-1:0] class_cnt_r [8];
   logic [CNT_W-1:0] other_cnt_r;
   logic [CNT_W-1:0] cycle_cnt_r;
   logic [CNT_W-1:0] retired_cnt_r;
   logic [CNT_W-1:0] drop_cnt_r;

   logic [EW-1:0]    mem_r [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             trace_valid_r;
   logic             fifo_full_r;
   logic [31:0]      trace_pc_r;
   logic [3:0]       trace_class_r;

   logic             run_s;
   logic [3:0]       retire_class_s;
   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic             limit_hit_s;
   logic [EW-1:0]    push_data_s;
   logic [EW-1:0]    head_s;
   logic [AW:0]      wr_ptr_n_s;
   logic [AW:0]      rd_ptr_n_s;
   logic             next_empty_s;
   logic             next_full_s;
   logic             unused_s;

   assign run_s          = (state_r == ST_RUN);
   assign retire_class_s = decode_class(retire_instr);
   assign full_s         = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign pop_s          = trace_valid_r && trace_ready;
   assign push_s         = retire_valid && run_s && (!full_s || pop_s);
   assign drop_s         = retire_valid && run_s && full_s && !pop_s;
   assign limit_hit_s    = (CYCLE_LIMIT != 0) && (cycle_cnt_r == LIMIT_M1);

`ifdef MON_WD_EN
   logic [31:0] trace_wd_r;
   assign push_data_s = {retire_pc, retire_class_s,
                         (retire_class_s <= 4'd4) ? retire_wd : 32'd0};
   assign trace_wd    = trace_wd_r;
   assign unused_s    = ^{1'b0, retire_instr[25:6]};
`else
   assign push_data_s = {retire_pc, retire_class_s};
   assign trace_wd    = 32'd0;
   assign unused_s    = ^{1'b0, retire_instr[25:6], retire_wd};
`endif

   // Next pointers and the entry that becomes the head after this edge.
   always_comb begin
      wr_ptr_n_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_n_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      // The entry being written this edge is not yet in memory, so bypass it.
      if (push_s && (rd_ptr_n_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
         head_s = push_data_s;
      end else begin
         head_s = mem_r[rd_ptr_n_s[AW-1:0]];
      end
      next_empty_s = (wr_ptr_n_s == rd_ptr_n_s);
      next_full_s  = (wr_ptr_n_s[AW-1:0] == rd_ptr_n_s[AW-1:0]) &&
                     (wr_ptr_n_s[AW] != rd_ptr_n_s[AW]);
   end

   // Trace storage array.
   always_ff @(posedge clk) begin
      if (push_s && !clr) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
      end
   end

   // FIFO pointers and registered head outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         trace_valid_r <= 1'b0;
         fifo_full_r   <= 1'b0;
         trace_pc_r    <= 32'd0;
         trace_class_r <= 4'd0;
`ifdef MON_WD_EN
         trace_wd_r    <= 32'd0;
`endif
      end else if (clr) begin
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         trace_valid_r <= 1'b0;
         fifo_full_r   <= 1'b0;
         trace_pc_r    <= 32'd0;
         trace_class_r <= 4'd0;
`ifdef MON_WD_EN
         trace_wd_r    <= 32'd0;
`endif
      end else begin
         wr_ptr_r      <= wr_ptr_n_s;
         rd_ptr_r      <= rd_ptr_n_s;
         trace_valid_r <= !next_empty_s;
         fifo_full_r   <= next_full_s;
         if (!next_empty_s) begin
            trace_pc_r    <= head_s[EW-1 -: 32];
            trace_class_r <= head_s[EW-33 -: 4];
`ifdef MON_WD_EN
            trace_wd_r    <= head_s[31:0];
`endif
         end else begin
            trace_pc_r    <= 32'd0;
            trace_class_r <= 4'd0;
`ifdef MON_WD_EN
            trace_wd_r    <= 32'd0;
`endif
         end
      end
   end

   // Saturating event counters; frozen outside RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) class_cnt_r[i] <= '0;
         other_cnt_r   <= '0;
         cycle_cnt_r   <= '0;
         retired_cnt_r <= '0;
         drop_cnt_r    <= '0;
      end else if (clr) begin
         for (int i = 0; i < 8; i++) class_cnt_r[i] <= '0;
         other_cnt_r   <= '0;
         cycle_cnt_r   <= '0;
         retired_cnt_r <= '0;
         drop_cnt_r    <= '0;
      end else if (run_s) begin
         cycle_cnt_r <= sat_inc(cycle_cnt_r);
         if (retire_valid) begin
            retired_cnt_r <= sat_inc(retired_cnt_r);
            if (!retire_class_s[3]) begin
               class_cnt_r[retire_class_s[2:0]] <= sat_inc(class_cnt_r[retire_class_s[2:0]]);
            end else begin
               other_cnt_r <= sat_inc(other_cnt_r);
            end
         end
         if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
         end
      end
   end

   // RUN/HALT state machine with registered halt flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
         halt_r  <= 1'b0;
      end else if (clr) begin
         state_r <= ST_RUN;
         halt_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (limit_hit_s) begin
                  state_r <= ST_HALT;
                  halt_r  <= 1'b1;
               end else begin
                  state_r <= ST_RUN;
                  halt_r  <= 1'b0;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
               halt_r  <= 1'b1;
            end
            default: begin
               state_r <= ST_RUN;
               halt_r  <= 1'b0;
            end
         endcase
      end
   end

   // Counter read mux.
   always_comb begin
      case (cnt_sel)
         4'd0, 4'd1, 4'd2, 4'd3,
         4'd4, 4'd5, 4'd6, 4'd7: cnt_rdata = class_cnt_r[cnt_sel[2:0]];
         4'd8:                   cnt_rdata = other_cnt_r;
         4'd9:                   cnt_rdata = cycle_cnt_r;
         4'd10:                  cnt_rdata = retired_cnt_r;
         4'd11:                  cnt_rdata = drop_cnt_r;
         default:                cnt_rdata = '0;
      endcase
   end

   assign trace_valid = trace_valid_r;
   assign trace_pc    = trace_pc_r;
   assign trace_class = trace_class_r;
   assign fifo_full   = fifo_full_r;
   assign halt        = halt_r;

endmodule

// File: tb/tb_pipeline_retire_monitor.sv
// Randomized self-checking bench for pipeline_retire_monitor against a queue-based reference model.
module tb_pipeline_retire_monitor;

   localparam int DEPTH = 8;
   localparam int LIMIT = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = 32'd0;
   logic [31:0] retire_instr = 32'd0;
   logic [31:0] retire_wd = 32'd0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [31:0] trace_pc;
   logic [3:0]  trace_class;
   logic [31:0] trace_wd;
   logic [3:0]  cnt_sel = 4'd0;
   logic [31:0] cnt_rdata;
   logic        halt;
   logic        fifo_full;

   pipeline_retire_monitor #(.CNT_W(32), .FIFO_DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .retire_valid(retire_valid), .retire_pc(retire_pc),
      .retire_instr(retire_instr), .retire_wd(retire_wd),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_class(trace_class), .trace_wd(trace_wd),
      .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata),
      .halt(halt), .fifo_full(fifo_full)
   );

   always #20 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [31:0] wd;
   } rec_t;

   rec_t            m_q[$];
   longint unsigned m_cnt[12];
   bit              m_halt;
   int              n_checks = 0;
   int              n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Class code as listed in the opcode/funct tables.
   function automatic logic [3:0] ref_class(input logic [31:0] instr);
      int op, fn;
      op = int'(instr[31:26]);
      fn = int'(instr[5:0]);
      if (op == 0) return (fn == 32) ? 4'd0 : (fn == 34) ? 4'd1 : (fn == 36) ? 4'd2 :
                          (fn == 37) ? 4'd3 : 4'd15;
      return (op == 35) ? 4'd4 : (op == 43) ? 4'd5 : (op == 4) ? 4'd6 : (op == 2) ? 4'd7 : 4'd15;
   endfunction

   // kinds 0-5: R-type funct 32,34,36,37,42,8; kinds 6-11: opcode 35,43,4,2,8,13
   function automatic logic [31:0] make_instr(input int kind);
      logic [31:0] w;
      w = $urandom;
      case (kind)
         0: begin w[31:26] = 6'd0; w[5:0] = 6'd32; end
         1: begin w[31:26] = 6'd0; w[5:0] = 6'd34; end
         2: begin w[31:26] = 6'd0; w[5:0] = 6'd36; end
         3: begin w[31:26] = 6'd0; w[5:0] = 6'd37; end
         4: begin w[31:26] = 6'd0; w[5:0] = 6'd42; end
         5: begin w[31:26] = 6'd0; w[5:0] = 6'd8;  end
         6: w[31:26] = 6'd35;
         7: w[31:26] = 6'd43;
         8: w[31:26] = 6'd4;
         9: w[31:26] = 6'd2;
         10: w[31:26] = 6'd8;
         default: w[31:26] = 6'd13;
      endcase
      return w;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 12; i++) m_cnt[i] = 0;
      m_q.delete();
      m_halt = 1'b0;
   endtask

   // One clock edge of the reference behaviour, from the current inputs.
   task automatic model_update();
      bit   will_halt;
      rec_t r;
      int   c;
      if (clr) begin
         model_clear();
         return;
      end
      if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
      if (!m_halt) begin
         will_halt = (LIMIT != 0) && (m_cnt[9] == longint'(LIMIT - 1));
         m_cnt[9]++;
         if (retire_valid) begin
            c = int'(ref_class(retire_instr));
            m_cnt[10]++;
            m_cnt[(c == 15) ? 8 : c]++;
            if (m_q.size() < DEPTH) begin
               r.pc  = retire_pc;
               r.cls = 4'(c);
`ifdef MON_WD_EN
               r.wd  = (c <= 4) ? retire_wd : 32'd0;
`else
               r.wd  = 32'd0;
`endif
               m_q.push_back(r);
            end else begin
               m_cnt[11]++;
            end
         end
         m_halt = will_halt;
      end
   endtask

   function automatic longint unsigned exp_cnt(input int sel);
      return (sel < 12) ? m_cnt[sel] : 64'd0;
   endfunction

   task automatic check_outputs(input string tag);
      int sel;
      check_val({tag, ".valid"}, 64'(trace_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         check_val({tag, ".pc"},    64'(trace_pc),    64'(m_q[0].pc));
         check_val({tag, ".class"}, 64'(trace_class), 64'(m_q[0].cls));
         check_val({tag, ".wd"},    64'(trace_wd),    64'(m_q[0].wd));
      end
      check_val({tag, ".full"}, 64'(fifo_full), 64'(m_q.size() == DEPTH));
      check_val({tag, ".halt"}, 64'(halt),      64'(m_halt));
      sel = $urandom_range(0, 15);
      cnt_sel = 4'(sel);
      #1;
      check_val($sformatf("%s.cnt%0d", tag, sel), 64'(cnt_rdata), exp_cnt(sel));
   endtask

   task automatic check_counters(input string tag);
      for (int s = 0; s < 16; s++) begin
         cnt_sel = 4'(s);
         #1;
         check_val($sformatf("%s.cnt%0d", tag, s), 64'(cnt_rdata), exp_cnt(s));
      end
   endtask

   task automatic step(input string tag);
      model_update();
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic drive_retire(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] wd);
      retire_valid = v;
      retire_pc    = pc;
      retire_instr = instr;
      retire_wd    = wd;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      drive_retire(1'b1, $urandom, make_instr($urandom_range(0, 11)), $urandom);
      trace_ready = 1'b1;
      step("clr");
      clr = 1'b0;
      drive_retire(1'b0, 32'd0, 32'd0, 32'd0);
   endtask

   initial begin
      model_clear();
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check_counters("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single ADD retire
      trace_ready = 1'b1;
      drive_retire(1'b1, 32'h0, 32'h00851020, 32'd5);
      step("add");
      check_counters("add");
      drive_retire(1'b0, 32'd0, 32'd0, 32'd0);
      step("add_drain");

      // LW, SW, BEQ, J, opcode 0x08 back to back
      do_clr();
      for (int k = 6; k <= 10; k++) begin
         drive_retire(1'b1, 32'h40 + 32'(k * 4), make_instr(k), $urandom);
         step("itype");
      end
      drive_retire(1'b0, 32'd0, 32'd0, 32'd0);
      step("itype_idle");
      check_counters("itype");

      // Overfill with the consumer stalled, then drain in order
      do_clr();
      trace_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_retire(1'b1, 32'h100 + 32'(i * 4), make_instr($urandom_range(0, 11)), $urandom);
         step("fill");
      end
      drive_retire(1'b0, 32'd0, 32'd0, 32'd0);
      check_counters("fill");
      trace_ready = 1'b1;
      for (int i = 0; i < 9; i++) step("drain");

      // Full FIFO with simultaneous retire and pop
      do_clr();
      trace_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_retire(1'b1, 32'h200 + 32'(i * 4), make_instr($urandom_range(0, 11)), $urandom);
         step("fill2");
      end
      trace_ready = 1'b1;
      drive_retire(1'b1, 32'h300, make_instr(0), 32'd7);
      step("full_pushpop");
      check_counters("full_pushpop");

      // Continuous retires until the cycle budget expires, then some frozen cycles
      do_clr();
      for (int i = 0; i < LIMIT + 40; i++) begin
         drive_retire(1'b1, $urandom, make_instr($urandom_range(0, 11)), $urandom);
         trace_ready = ($urandom_range(0, 9) < 3);
         step("budget");
      end
      cnt_sel = 4'd9;
      #1;
      check_val("cycles_at_halt", 64'(cnt_rdata), 64'(LIMIT));
      check_val("halt_high", 64'(halt), 64'd1);
      check_counters("halted");

      // Asynchronous reset between edges while halted with a non-empty FIFO
      trace_ready = 1'b0;
      step("pre_rst");
      cnt_sel = 4'd9;
      #8;
      rst = 1'b1;
      #1;
      check_val("rst_async.valid", 64'(trace_valid), 64'd0);
      check_val("rst_async.halt",  64'(halt),        64'd0);
      check_val("rst_async.cycles", 64'(cnt_rdata),  64'd0);
      cnt_sel = 4'd10;
      #1;
      check_val("rst_async.retired", 64'(cnt_rdata), 64'd0);
      #1;
      rst = 1'b0;
      model_clear();
      check_counters("post_rst");

      // Random traffic with occasional clear
      for (int i = 0; i < 300; i++) begin
         clr = ($urandom_range(0, 39) == 0);
         drive_retire(($urandom_range(0, 9) < 7), $urandom,
                      make_instr($urandom_range(0, 11)), $urandom);
         trace_ready = $urandom_range(0, 1);
         step("random");
      end
      clr = 1'b0;
      check_counters("final");

      // Clear leaves HALT and zeroes everything
      do_clr();
      check_counters("clr_final");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
